// File: rtl/uart_rx_cmd_ctrl_if.sv
// Purpose: bundles the UART command controller's RX byte input and its
//          register-file / ALU command outputs into one interface.
// Signals:
//   rx_p_data, rx_d_vld              received byte and its one-cycle valid
//   rf_wr_en, rf_rd_en               register-file write / read strobes
//   rf_address, rf_wr_data           register-file address and write data
//   alu_en, alu_fun                  ALU operation strobe and function
//   clk_gate_en                      ALU clock enable
//   cmd_busy, cmd_err                frame in progress / malformed-frame pulse
// Modports: slave = controller side, master = byte source / command sink side.
interface uart_rx_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
);
  logic [DATA_W-1:0] rx_p_data;
  logic              rx_d_vld;
  logic              rf_wr_en;
  logic              rf_rd_en;
  logic [ADDR_W-1:0] rf_address;
  logic [DATA_W-1:0] rf_wr_data;
  logic              alu_en;
  logic [FUN_W-1:0]  alu_fun;
  logic              clk_gate_en;
  logic              cmd_busy;
  logic              cmd_err;

  modport slave (
    input  rx_p_data, rx_d_vld,
    output rf_wr_en, rf_rd_en, rf_address, rf_wr_data,
           alu_en, alu_fun, clk_gate_en, cmd_busy, cmd_err
  );

  modport master (
    output rx_p_data, rx_d_vld,
    input  rf_wr_en, rf_rd_en, rf_address, rf_wr_data,
           alu_en, alu_fun, clk_gate_en, cmd_busy, cmd_err
  );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// Purpose: parses the synchronised UART RX byte stream into register-file
//          write/read and ALU commands, issuing one-cycle strobes, driving the
//          ALU clock-gate enable and aborting stalled frames on an inter-byte
//          timeout.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   bus      uart_rx_cmd_ctrl_if.slave (RX byte in, RF/ALU commands out)
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | waiting for an opcode byte
// WR_ADDR | RF write: waiting for the address byte
// WR_DATA | RF write: waiting for the data byte
// RD_ADDR | RF read: waiting for the address byte
// A_OPA   | ALU with operands: waiting for operand A (RF addr 0)
// A_OPB   | ALU with operands: waiting for operand B (RF addr 1)
// A_FUN   | ALU with operands: waiting for the function byte
// N_FUN   | ALU without operands: waiting for the function byte
module uart_rx_cmd_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int FUN_W       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                clk_i,
  input logic                rst_ni,
  uart_rx_cmd_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, A_OPA, A_OPB, A_FUN, N_FUN
  } state_e;

  localparam logic [DATA_W-1:0] OP_WR  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] OP_RD  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] OP_ALU = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] OP_NOP = DATA_W'(8'hDD);

  // The counter only ever needs to hold 0 .. TIMEOUT_CYC-1.
  localparam int                CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int                TC_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0]  TC_LAST   = CNT_W'(TC_LAST_I);
  localparam bit                TO_EN     = (TIMEOUT_CYC > 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_hold_q, addr_hold_d;
  logic               rf_wr_en_q, rf_wr_en_d;
  logic               rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_W-1:0]  rf_address_q, rf_address_d;
  logic [DATA_W-1:0]  rf_wr_data_q, rf_wr_data_d;
  logic               alu_en_q, alu_en_d;
  logic [FUN_W-1:0]   alu_fun_q, alu_fun_d;
  logic               clk_gate_en_q, clk_gate_en_d;
  logic               cmd_busy_q, cmd_busy_d;
  logic               cmd_err_q, cmd_err_d;
  logic               timeout_hit;

  logic [DATA_W-1:0]  rx_data;
  logic               rx_vld;
  logic               unused_rx_bits;

  assign rx_data = bus.rx_p_data;
  assign rx_vld  = bus.rx_d_vld;
  // Upper byte bits are deliberately dropped for address/function fields.
  assign unused_rx_bits = ^rx_data;

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = TO_EN && (state_q != IDLE) && !rx_vld && (cnt_q == TC_LAST);

  always_comb begin
    state_d      = state_q;
    addr_hold_d  = addr_hold_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    cmd_err_d    = 1'b0;
    rf_address_d = rf_address_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;

    case (state_q)
      IDLE: begin
        if (rx_vld) begin
          case (rx_data)
            OP_WR:   state_d = WR_ADDR;
            OP_RD:   state_d = RD_ADDR;
            OP_ALU:  state_d = A_OPA;
            OP_NOP:  state_d = N_FUN;
            default: cmd_err_d = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        // Address is parked until the data byte so RF_Address moves only with its strobe.
        if (rx_vld) begin
          addr_hold_d = rx_data[ADDR_W-1:0];
          state_d     = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_vld) begin
          rf_wr_en_d   = 1'b1;
          rf_address_d = addr_hold_q;
          rf_wr_data_d = rx_data;
          state_d      = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_vld) begin
          rf_rd_en_d   = 1'b1;
          rf_address_d = rx_data[ADDR_W-1:0];
          state_d      = IDLE;
        end
      end
      A_OPA: begin
        if (rx_vld) begin
          rf_wr_en_d   = 1'b1;
          rf_address_d = ADDR_W'(0);
          rf_wr_data_d = rx_data;
          state_d      = A_OPB;
        end
      end
      A_OPB: begin
        if (rx_vld) begin
          rf_wr_en_d   = 1'b1;
          rf_address_d = ADDR_W'(1);
          rf_wr_data_d = rx_data;
          state_d      = A_FUN;
        end
      end
      A_FUN, N_FUN: begin
        if (rx_vld) begin
          alu_en_d  = 1'b1;
          alu_fun_d = rx_data[FUN_W-1:0];
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_hit) begin
      state_d   = IDLE;
      cmd_err_d = 1'b1;
    end

    if (!TO_EN || (state_q == IDLE) || rx_vld || timeout_hit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Gate stays open through the ALU_EN cycle itself, then drops.
    clk_gate_en_d = (state_d == A_OPA) || (state_d == A_OPB) ||
                    (state_d == A_FUN) || (state_d == N_FUN) || alu_en_d;
    cmd_busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_hold_q   <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_address_q  <= '0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      cmd_busy_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_hold_q   <= addr_hold_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_address_q  <= rf_address_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      cmd_busy_q    <= cmd_busy_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign bus.rf_wr_en    = rf_wr_en_q;
  assign bus.rf_rd_en    = rf_rd_en_q;
  assign bus.rf_address  = rf_address_q;
  assign bus.rf_wr_data  = rf_wr_data_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_fun     = alu_fun_q;
  assign bus.clk_gate_en = clk_gate_en_q;
  assign bus.cmd_busy    = cmd_busy_q;
  assign bus.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: directed frames followed by a random byte
// stream, every cycle compared against a frame-level reference model.
module tb_uart_rx_cmd_ctrl;
  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;

  uart_rx_cmd_ctrl_if #(.DATA_W(8), .ADDR_W(4), .FUN_W(4)) bus ();

  uart_rx_cmd_ctrl #(
    .DATA_W(8), .ADDR_W(4), .FUN_W(4), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks the open frame as opcode + collected payload bytes.
  bit         m_open;
  logic [7:0] m_op;
  int         m_got;
  int         m_idle;
  logic [7:0] m_pay [3];

  logic       e_wr, e_rd, e_alu, e_err, e_busy, e_gate;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_wdata;

  function automatic int frame_len(input logic [7:0] op);
    case (op)
      8'hAA:   return 2;
      8'hCC:   return 3;
      default: return 1;
    endcase
  endfunction

  function automatic void model_reset();
    m_open  = 1'b0;
    m_op    = 8'h00;
    m_got   = 0;
    m_idle  = 0;
    e_wr    = 1'b0;
    e_rd    = 1'b0;
    e_alu   = 1'b0;
    e_err   = 1'b0;
    e_busy  = 1'b0;
    e_gate  = 1'b0;
    e_addr  = 4'h0;
    e_fun   = 4'h0;
    e_wdata = 8'h00;
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] b);
    logic [7:0] p0;
    e_wr  = 1'b0;
    e_rd  = 1'b0;
    e_alu = 1'b0;
    e_err = 1'b0;
    if (!m_open) begin
      m_idle = 0;
      if (v) begin
        if (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) begin
          m_open = 1'b1;
          m_op   = b;
          m_got  = 0;
        end else begin
          e_err = 1'b1;
        end
      end
    end else if (v) begin
      m_pay[m_got] = b;
      m_got++;
      m_idle = 0;
      p0 = m_pay[0];
      case (m_op)
        8'hAA: if (m_got == 2) begin
          e_wr = 1'b1; e_addr = p0[3:0]; e_wdata = b;
        end
        8'hBB: begin
          e_rd = 1'b1; e_addr = b[3:0];
        end
        8'hCC: if (m_got < 3) begin
          e_wr = 1'b1; e_addr = 4'(m_got - 1); e_wdata = b;
        end else begin
          e_alu = 1'b1; e_fun = b[3:0];
        end
        default: begin
          e_alu = 1'b1; e_fun = b[3:0];
        end
      endcase
      if (m_got == frame_len(m_op)) m_open = 1'b0;
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_open = 1'b0;
        e_err  = 1'b1;
      end
    end
    e_busy = m_open;
    e_gate = (m_open && (m_op == 8'hCC || m_op == 8'hDD)) || e_alu;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("rf_wr_en",    32'(bus.rf_wr_en),    32'(e_wr));
    chk("rf_rd_en",    32'(bus.rf_rd_en),    32'(e_rd));
    chk("alu_en",      32'(bus.alu_en),      32'(e_alu));
    chk("rf_address",  32'(bus.rf_address),  32'(e_addr));
    chk("rf_wr_data",  32'(bus.rf_wr_data),  32'(e_wdata));
    chk("alu_fun",     32'(bus.alu_fun),     32'(e_fun));
    chk("clk_gate_en", 32'(bus.clk_gate_en), 32'(e_gate));
    chk("cmd_busy",    32'(bus.cmd_busy),    32'(e_busy));
    chk("cmd_err",     32'(bus.cmd_err),     32'(e_err));
  endtask

  // One clock: present (v,b), let the edge sample it, then compare.
  task automatic step(input bit v, input logic [7:0] b);
    bus.rx_d_vld  = v;
    bus.rx_p_data = v ? b : 8'($urandom);
    @(posedge clk);
    #1;
    cyc++;
    bus.rx_d_vld = 1'b0;
    model_step(v, b);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
    step(1'b1, a);
    if (n > 1) step(1'b1, b);
    if (n > 2) step(1'b1, c);
  endtask

  initial begin
    logic [7:0] op;
    int         len;
    int         gap;
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.rx_d_vld  = 1'b0;
    bus.rx_p_data = 8'h00;
    model_reset();

    // Reset state
    #3;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // RF write with gaps between bytes
    step(1'b1, 8'hAA); idle(3);
    step(1'b1, 8'h05); idle(2);
    step(1'b1, 8'h3C); idle(2);
    // RF read
    send3(8'hBB, 8'h0F, 8'h00, 2); idle(1);
    // RF read with truncated address
    send3(8'hBB, 8'hF3, 8'h00, 2); idle(1);
    // ALU with operands, back-to-back
    send3(8'hCC, 8'h12, 8'h34, 3); step(1'b1, 8'h02); idle(2);
    // ALU without operands, then unknown opcode
    send3(8'hDD, 8'h07, 8'h00, 2); idle(1);
    step(1'b1, 8'h5A); idle(2);
    // Payload 0xAA is data, not an opcode
    send3(8'hAA, 8'h09, 8'hAA, 3); idle(1);

    // Timeout expires after 16 idle cycles
    send3(8'hAA, 8'h03, 8'h00, 2); idle(TO + 2);
    // Byte on the expiry cycle is accepted
    send3(8'hAA, 8'h03, 8'h00, 2); idle(TO - 1); step(1'b1, 8'h77); idle(2);
    // Timeout inside an ALU frame
    send3(8'hCC, 8'h44, 8'h00, 2); idle(TO + 1);

    // Reset mid-frame after CC,11
    send3(8'hCC, 8'h11, 8'h00, 2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    rst_n = 1'b1;
    send3(8'hDD, 8'h01, 8'h00, 2); idle(2);

    // Random stream of frames, junk opcodes and occasional stalls
    for (int f = 0; f < 80; f++) begin
      case ($urandom_range(0, 4))
        0: op = 8'hAA;
        1: op = 8'hBB;
        2: op = 8'hCC;
        3: op = 8'hDD;
        default: op = 8'($urandom);
      endcase
      len = (op inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) ? frame_len(op) : 0;
      step(1'b1, op);
      for (int k = 0; k < len; k++) begin
        gap = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 2)
                                          : $urandom_range(0, 3);
        idle(gap);
        step(1'b1, 8'($urandom));
      end
      idle($urandom_range(0, 3));
    end
    idle(TO + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
